pattern_sweep_misr: RTL and testbench
=====================================

// Module: pattern_sweep_misr
// PURPOSE
// Stimulus/response stage placed around a combinational regression netlist (pi*/po* ports).
// Drives every input pattern 0..2^NUM_PI-1 onto the netlist pis, one pattern per cycle.
// Compacts the returned pos into a MISR signature and compares it with an expected value.
// Lets golden and optimized netlists be checked for equivalence in simulation or on FPGA.
// PARAMETERS
// NUM_PI     4        netlist input count (1..20)
// NUM_PO     4        netlist output count (1..SIG_W)
// SIG_W      16       MISR width
// MISR_POLY  16'h1021 feedback taps, XORed in when the shifted-out MSB is 1
// MISR_SEED  16'h0000 signature value at reset/start
// DUT_LAT    0        register stages between pi and po inside the netlist wrapper (0..7)
// PORTS
// clk           in   1       single clock
// rst           in   1       synchronous, active-high reset
// start         in   1       launch a sweep; sampled only in IDLE or DONE
// expected_sig  in   SIG_W   golden signature; sampled when DONE is entered
// pi            out  NUM_PI  registered pattern driven to the netlist
// po            in   NUM_PO  netlist response
// busy          out  1       high in DRIVE and DRAIN
// done          out  1       high in DONE
// pass          out  1       (signature == expected_sig), valid while done
// signature     out  SIG_W   current MISR value
// pattern_count out  NUM_PI+1 number of responses absorbed so far
// BEHAVIOUR
// - Reset (rst high at an edge):
//   - state=IDLE; pi=0; busy=0; done=0; pass=0; signature=MISR_SEED; pattern_count=0.
//   - Reset in any state aborts the sweep. No partial result is retained.
// - FSM states: IDLE, DRIVE, DRAIN, DONE.
//   - IDLE / DONE + start: go to DRIVE; pi=0; cnt=0; signature=MISR_SEED; pattern_count=0; done=0; pass=0.
//   - DRIVE: each edge increments cnt and sets pi=cnt+1.
//     - At the edge where cnt==2^NUM_PI-1: go to DRAIN if DUT_LAT>0, otherwise DONE. pi holds the last pattern.
//   - DRAIN: wait DUT_LAT cycles, counted by a small down-counter. pi held. Then go to DONE.
//   - DONE: done=1. pass is registered on DONE entry and stays held. pi is held.
//     - Stay in DONE until start (restart) or rst.
// - start while busy is ignored. start is level-sampled, so holding it high in DONE restarts the sweep every time.
// - Capture alignment:
//   - A valid bit is set for every DRIVE cycle and delayed DUT_LAT stages.
//   - At each edge where the delayed valid is 1, po is absorbed into the MISR.
//   - Exactly 2^NUM_PI responses are absorbed. done rises exactly 2^NUM_PI+DUT_LAT edges after the start edge.
// - MISR update: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ zero-extended po.
//   - pattern_count increments with each absorb.
// - Widths:
//   - cnt is NUM_PI+1 bits, so the terminal compare never wraps.
//   - pattern_count saturates at 2^NUM_PI by construction.
// - po is X-free by contract. No X-masking is done.
// STRUCTURE
// - Shared package: state enum (IDLE/DRIVE/DRAIN/DONE) and the default MISR_POLY constant.
// - One sub-module, misr_reg: parameterized SIG_W/POLY/SEED register with clear and enable inputs.
// - FSM, pattern counter and valid delay line stay in the top module.
// TESTING
// 1. NUM_PI=4, DUT_LAT=0, po tied 0, expected=0, pulse start.
//    -> pi steps 0..15, busy for 16 cycles, done on the 16th edge, signature=16'h0000, pass=1.
// 2. NUM_PI=2, NUM_PO=2, po=pi, seed 0.
//    -> absorbs 0,1,2,3; signature=16'h0003; pattern_count=4; pass=1 with expected=16'h0003.
// 3. Feedback check: SIG_W=4, MISR_POLY=4'h3, MISR_SEED=4'h8, NUM_PI=1, po=0.
//    -> signature 8 -> 3 -> 6; final 4'h6.
// 4. Repeat case 2 with expected=16'h0004.
//    -> done=1, pass=0. Then assert start in DONE: sweep reruns from seed with the same signature.
// 5. Repeat case 2 with DUT_LAT=2 (bench delays po by 2 registers).
//    -> done 2 edges later than case 2, signature still 16'h0003.
// 6. Case 1, assert rst when pi=5.
//    -> next cycle: IDLE, pi=0, busy=0, signature=seed, pattern_count=0. A start pulse during busy in a fresh run does not restart the sweep.

Source files
------------

// File: rtl/pattern_sweep_misr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sweep_misr_pkg
// Description : Shared types and constants for the pattern sweep / MISR
//               response compactor: sweep FSM state encoding and the default
//               MISR feedback polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_sweep_misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // CCITT-style taps; applied when the bit shifted out of the MSB is 1.
  localparam logic [15:0] c_default_misr_poly = 16'h1021;

endpackage : pattern_sweep_misr_pkg
`default_nettype wire

// File: rtl/pattern_sweep_misr_misr_reg.sv
`default_nettype none
// ============================================================================
// Module      : misr_reg
// Description : Multiple-input signature register. Shifts left, folds POLY in
//               when the outgoing MSB is set, and XORs the parallel input.
// Ports       : clk, rst      - clock, synchronous active-high reset (-> SEED)
//               i_clr         - synchronous reload of SEED
//               i_en          - absorb i_din this cycle
//               i_din         - parallel data to compact
//               o_sig         - current signature
//               o_sig_next    - value the register takes on the next edge
//                               (ignoring rst/i_clr)
// Revision    : 1.0 - initial release
// ============================================================================
module misr_reg
  import pattern_sweep_misr_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(c_default_misr_poly),
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [SIG_W-1:0] i_din,
  output logic [SIG_W-1:0] o_sig,
  output logic [SIG_W-1:0] o_sig_next
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_absorbed;

  always_comb begin
    w_absorbed = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ i_din;
    o_sig_next = i_en ? w_absorbed : r_sig;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_absorbed;
    end
  end

  assign o_sig = r_sig;

endmodule : misr_reg
`default_nettype wire

// File: rtl/pattern_sweep_misr.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sweep_misr
// Description : Exhaustive stimulus / signature stage for a combinational
//               netlist. Drives patterns 0..2^NUM_PI-1 on pi (one per cycle),
//               compacts the po responses (DUT_LAT cycles later) into a MISR,
//               and compares the final signature with expected_sig.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               start          - launch a sweep (honoured in IDLE/DONE only)
//               expected_sig   - golden signature, sampled on DONE entry
//               pi / po        - netlist stimulus / response
//               busy, done     - sweep in progress / sweep complete
//               pass           - signature matched, valid while done
//               signature      - current MISR value
//               pattern_count  - responses absorbed so far
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_sweep_misr
  import pattern_sweep_misr_pkg::*;
#(
  parameter int               NUM_PI    = 4,
  parameter int               NUM_PO    = 4,
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(c_default_misr_poly),
  parameter logic [SIG_W-1:0] MISR_SEED = '0,
  parameter int               DUT_LAT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic [NUM_PI-1:0] pi,
  input  logic [NUM_PO-1:0] po,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [NUM_PI:0]   pattern_count
);

  localparam int              c_cnt_w      = NUM_PI + 1;
  localparam logic [NUM_PI:0] c_last       = c_cnt_w'((1 << NUM_PI) - 1);
  localparam logic [2:0]      c_drain_init = 3'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);

  state_t            r_state;
  logic [NUM_PI:0]   r_cnt;
  logic [NUM_PI-1:0] r_pi;
  logic [2:0]        r_drain;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [NUM_PI:0]   r_pcount;

  logic              w_start_sweep;
  logic              w_absorb;
  logic              w_match;
  logic [SIG_W-1:0]  w_po_ext;
  logic [SIG_W-1:0]  w_sig;
  logic [SIG_W-1:0]  w_sig_next;

  assign w_start_sweep = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_po_ext             = '0;
    w_po_ext[NUM_PO-1:0] = po;
  end

  // The last response is absorbed on the same edge that enters DONE, so the
  // comparison looks at the post-absorb value.
  assign w_match = (w_sig_next == expected_sig);

  // Valid tag follows each driven pattern through the netlist latency.
  generate
    if (DUT_LAT == 0) begin : g_lat0
      assign w_absorb = (r_state == ST_DRIVE);
    end else begin : g_latn
      logic [DUT_LAT-1:0] r_vpipe;
      always_ff @(posedge clk) begin
        if (rst || w_start_sweep) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= (r_vpipe << 1) | DUT_LAT'(r_state == ST_DRIVE);
        end
      end
      assign w_absorb = r_vpipe[DUT_LAT-1];
    end
  endgenerate

  misr_reg #(
    .SIG_W (SIG_W),
    .POLY  (MISR_POLY),
    .SEED  (MISR_SEED)
  ) u_misr (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start_sweep),
    .i_en       (w_absorb),
    .i_din      (w_po_ext),
    .o_sig      (w_sig),
    .o_sig_next (w_sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst || w_start_sweep) begin
      r_pcount <= '0;
    end else if (w_absorb) begin
      r_pcount <= r_pcount + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pi    <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_DRIVE;
            r_cnt   <= '0;
            r_pi    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            // pi keeps the last pattern while the pipeline empties.
            r_drain <= c_drain_init;
            if (DUT_LAT > 0) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_match;
            end
          end else begin
            r_pi <= NUM_PI'(r_cnt + 1'b1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == 3'd0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_match;
          end else begin
            r_drain <= r_drain - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pi            = r_pi;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign signature     = w_sig;
  assign pattern_count = r_pcount;

endmodule : pattern_sweep_misr
`default_nettype wire

// File: tb/tb_pattern_sweep_misr.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_sweep_misr
// Description : Self-checking bench for pattern_sweep_misr. Four instances
//               cover the default 4-input sweep, a 2-input echo netlist with
//               zero and two cycles of latency, and a 4-bit MISR feedback case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sweep_misr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // u1: NUM_PI=4, DUT_LAT=0, po tied low
  logic        rst1, st1;
  logic [15:0] exp1;
  logic [3:0]  pi1;
  logic        busy1, done1, pass1;
  logic [15:0] sig1;
  logic [4:0]  pc1;

  // u2: NUM_PI=2, NUM_PO=2, po=pi
  logic        rst, st2;
  logic [15:0] exp2;
  logic [1:0]  pi2;
  logic        busy2, done2, pass2;
  logic [15:0] sig2;
  logic [2:0]  pc2;

  // u3: SIG_W=4, POLY=3, SEED=8, NUM_PI=1, po=0
  logic        st3;
  logic [3:0]  exp3;
  logic [0:0]  pi3;
  logic        busy3, done3, pass3;
  logic [3:0]  sig3;
  logic [1:0]  pc3;

  // u5: as u2 but po is pi delayed by two registers, DUT_LAT=2
  logic        st5;
  logic [15:0] exp5;
  logic [1:0]  pi5, po5_d1, po5_d2;
  logic        busy5, done5, pass5;
  logic [15:0] sig5;
  logic [2:0]  pc5;

  always @(posedge clk) begin
    po5_d1 <= pi5;
    po5_d2 <= po5_d1;
  end

  pattern_sweep_misr u1 (
    .clk(clk), .rst(rst1), .start(st1), .expected_sig(exp1), .pi(pi1), .po(4'b0000),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .pattern_count(pc1));

  pattern_sweep_misr #(.NUM_PI(2), .NUM_PO(2)) u2 (
    .clk(clk), .rst(rst), .start(st2), .expected_sig(exp2), .pi(pi2), .po(pi2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pattern_count(pc2));

  pattern_sweep_misr #(.NUM_PI(1), .NUM_PO(1), .SIG_W(4), .MISR_POLY(4'h3), .MISR_SEED(4'h8)) u3 (
    .clk(clk), .rst(rst), .start(st3), .expected_sig(exp3), .pi(pi3), .po(1'b0),
    .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .pattern_count(pc3));

  pattern_sweep_misr #(.NUM_PI(2), .NUM_PO(2), .DUT_LAT(2)) u5 (
    .clk(clk), .rst(rst), .start(st5), .expected_sig(exp5), .pi(pi5), .po(po5_d2),
    .busy(busy5), .done(done5), .pass(pass5), .signature(sig5), .pattern_count(pc5));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-edge expectations for u2 (latency 0) and u5 (latency 2), both started
  // on the same edge; row k is sampled just after edge k (k=0 is the start edge).
  typedef struct {
    logic [1:0]  pi2;  logic [15:0] sig2; logic [2:0] pc2; logic busy2; logic done2;
    logic [1:0]  pi5;  logic [15:0] sig5; logic [2:0] pc5; logic busy5; logic done5;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd0, 16'h0, 3'd0, 1'b1, 1'b0,  2'd0, 16'h0, 3'd0, 1'b1, 1'b0};
    tbl[1] = '{2'd1, 16'h0, 3'd1, 1'b1, 1'b0,  2'd1, 16'h0, 3'd0, 1'b1, 1'b0};
    tbl[2] = '{2'd2, 16'h1, 3'd2, 1'b1, 1'b0,  2'd2, 16'h0, 3'd0, 1'b1, 1'b0};
    tbl[3] = '{2'd3, 16'h0, 3'd3, 1'b1, 1'b0,  2'd3, 16'h0, 3'd1, 1'b1, 1'b0};
    tbl[4] = '{2'd3, 16'h3, 3'd4, 1'b0, 1'b1,  2'd3, 16'h1, 3'd2, 1'b1, 1'b0};
    tbl[5] = '{2'd3, 16'h3, 3'd4, 1'b0, 1'b1,  2'd3, 16'h0, 3'd3, 1'b1, 1'b0};
    tbl[6] = '{2'd3, 16'h3, 3'd4, 1'b0, 1'b1,  2'd3, 16'h3, 3'd4, 1'b0, 1'b1};

    rst1 = 1'b1; rst = 1'b1;
    st1 = 1'b0; st2 = 1'b0; st3 = 1'b0; st5 = 1'b0;
    exp1 = 16'h0000; exp2 = 16'h0003; exp3 = 4'h6; exp5 = 16'h0003;
    tick(); tick();
    rst1 = 1'b0; rst = 1'b0;

    // Reset state
    chk("rst_pi1", pi1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_pass1", pass1, 0);
    chk("rst_pc1", pc1, 0);
    chk("rst_sig3_seed", sig3, 4'h8);
    chk("rst_done2", done2, 0);

    // Case 1: 16 patterns, po=0
    st1 = 1'b1; tick(); st1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      chk($sformatf("c1_pi_e%0d", k), pi1, k);
      chk($sformatf("c1_busy_e%0d", k), busy1, 1);
      chk($sformatf("c1_done_e%0d", k), done1, 0);
    end
    tick();
    chk("c1_done", done1, 1);
    chk("c1_busy_end", busy1, 0);
    chk("c1_pi_hold", pi1, 15);
    chk("c1_sig", sig1, 16'h0000);
    chk("c1_pc", pc1, 16);
    chk("c1_pass", pass1, 1);

    // Cases 2 and 5 side by side from the table
    st2 = 1'b1; st5 = 1'b1; tick(); st2 = 1'b0; st5 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      chk($sformatf("c2_pi_e%0d", k), pi2, tbl[k].pi2);
      chk($sformatf("c2_sig_e%0d", k), sig2, tbl[k].sig2);
      chk($sformatf("c2_pc_e%0d", k), pc2, tbl[k].pc2);
      chk($sformatf("c2_busy_e%0d", k), busy2, tbl[k].busy2);
      chk($sformatf("c2_done_e%0d", k), done2, tbl[k].done2);
      chk($sformatf("c5_pi_e%0d", k), pi5, tbl[k].pi5);
      chk($sformatf("c5_sig_e%0d", k), sig5, tbl[k].sig5);
      chk($sformatf("c5_pc_e%0d", k), pc5, tbl[k].pc5);
      chk($sformatf("c5_busy_e%0d", k), busy5, tbl[k].busy5);
      chk($sformatf("c5_done_e%0d", k), done5, tbl[k].done5);
    end
    chk("c2_pass", pass2, 1);
    chk("c5_pass", pass5, 1);

    // Case 3: feedback 8 -> 3 -> 6
    st3 = 1'b1; tick(); st3 = 1'b0;
    chk("c3_sig_e0", sig3, 4'h8);
    chk("c3_busy_e0", busy3, 1);
    tick();
    chk("c3_sig_e1", sig3, 4'h3);
    chk("c3_done_e1", done3, 0);
    tick();
    chk("c3_sig_e2", sig3, 4'h6);
    chk("c3_done_e2", done3, 1);
    chk("c3_pass", pass3, 1);
    chk("c3_pc", pc3, 2);

    // Case 4: wrong golden, then two restarts from DONE
    exp2 = 16'h0004;
    for (int r = 0; r < 2; r++) begin
      st2 = 1'b1; tick(); st2 = 1'b0;
      chk($sformatf("c4_r%0d_restart_sig", r), sig2, 16'h0000);
      chk($sformatf("c4_r%0d_restart_done", r), done2, 0);
      chk($sformatf("c4_r%0d_restart_pc", r), pc2, 0);
      repeat (4) tick();
      chk($sformatf("c4_r%0d_done", r), done2, 1);
      chk($sformatf("c4_r%0d_sig", r), sig2, 16'h0003);
      chk($sformatf("c4_r%0d_pass", r), pass2, 0);
    end

    // Case 6: reset mid-sweep, then start ignored while busy
    st1 = 1'b1; tick(); st1 = 1'b0;
    begin
      int n;
      n = 0;
      while (pi1 != 4'd5 && n < 40) begin
        tick();
        n++;
      end
      chk("c6_reach_pi5", (pi1 == 4'd5), 1);
    end
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    chk("c6_rst_pi", pi1, 0);
    chk("c6_rst_busy", busy1, 0);
    chk("c6_rst_done", done1, 0);
    chk("c6_rst_sig", sig1, 16'h0000);
    chk("c6_rst_pc", pc1, 0);
    tick();
    chk("c6_idle_busy", busy1, 0);

    st1 = 1'b1; tick(); st1 = 1'b0;       // edge 0
    repeat (3) tick();                    // edge 3, pi=3
    st1 = 1'b1; tick(); st1 = 1'b0;       // edge 4, start while busy
    chk("c6_busy_start_pi", pi1, 4);
    chk("c6_busy_start_busy", busy1, 1);
    chk("c6_busy_start_pc", pc1, 4);
    repeat (11) tick();                   // edge 15
    chk("c6_e15_done", done1, 0);
    tick();                               // edge 16
    chk("c6_e16_done", done1, 1);
    chk("c6_e16_pc", pc1, 16);
    chk("c6_e16_pass", pass1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pattern_sweep_misr
`default_nettype wire
